wb_mult5_slave: RTL and testbench

WB_MULT5_SLAVE -- requirements
Module: wb_mult5_slave

---
 rtl/wb_mult5_pkg.sv | 28 ++
 rtl/mult5_seq.sv | 65 ++++++
 rtl/wb_mult5_slave.sv | 106 ++++++++++
 tb/tb_wb_mult5_slave.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mult5_pkg.sv
// Shared constants for the Wishbone 5x5 multiplier slave.
// Contents: register word indices, bit-field positions, datapath widths and FSM states.
package wb_mult5_pkg;

    localparam int OPERAND_W = 5;
    localparam int RESULT_W  = 10;
    localparam int OPS_W     = 2 * OPERAND_W;
    localparam int CNT_W     = 3;

    // Word indices, i.e. byte offset [7:2]
    localparam logic [5:0] REG_OPERANDS = 6'h00;
    localparam logic [5:0] REG_CTRL     = 6'h01;
    localparam logic [5:0] REG_STATUS   = 6'h02;
    localparam logic [5:0] REG_RESULT   = 6'h03;

    localparam int OP_A_LSB         = 0;
    localparam int OP_B_LSB         = OPERAND_W;
    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_IRQ_EN_BIT  = 1;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mult_state_e;

endpackage

// File: rtl/mult5_seq.sv
// Sequential shift-add multiplier: one partial product per cycle over five cycles.
// start is honoured only in IDLE; done pulses for one cycle as result updates.
module mult5_seq
    import wb_mult5_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [RESULT_W-1:0]  result
);

    mult_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [OPERAND_W-1:0] a_q;
    logic [OPERAND_W-1:0] b_q;
    logic [RESULT_W-1:0]  acc_q;
    logic [RESULT_W-1:0]  addend;
    logic [RESULT_W-1:0]  acc_next;

    assign addend   = a_q[cnt_q] ? ({{OPERAND_W{1'b0}}, b_q} << cnt_q) : '0;
    assign acc_next = acc_q + addend;
    assign busy     = (state_q == ST_RUN);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'(OPERAND_W - 1)) begin
                        result  <= acc_next;
                        done    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wb_mult5_slave.sv
// Wishbone classic slave fronting the 5x5 multiplier.
// Holds the bus decode and the OPERANDS/CTRL/STATUS registers; arithmetic lives in mult5_seq.
module wb_mult5_slave
    import wb_mult5_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq_o
);

    logic                in_window;
    logic                wr_en;
    logic [5:0]          reg_idx;
    logic [OPS_W-1:0]    operands_q, operands_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic                seq_start, seq_busy, seq_done;
    logic [RESULT_W-1:0] seq_result;
    logic [31:0]         rdata;
    logic                unused_bits;

    // The ~ack term forces a dead cycle after every ack, so each request is taken once.
    assign in_window = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o
                     & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign reg_idx   = wbs_adr_i[7:2];
    assign wr_en     = in_window & wbs_we_i;
    assign seq_start = wr_en && (reg_idx == REG_CTRL) && wbs_sel_i[0]
                     && wbs_dat_i[CTRL_START_BIT];
    assign unused_bits = ^{wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i[31:OPS_W]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        operands_d = operands_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        if (wr_en && wbs_sel_i[0]) begin
            case (reg_idx)
                REG_OPERANDS: operands_d[7:0] = wbs_dat_i[7:0];
                REG_CTRL:     irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
                REG_STATUS:   if (wbs_dat_i[STATUS_DONE_BIT]) done_d = 1'b0;
                default: ;
            endcase
        end
        if (wr_en && wbs_sel_i[1] && (reg_idx == REG_OPERANDS))
            operands_d[OPS_W-1:8] = wbs_dat_i[OPS_W-1:8];
        if (seq_start && !seq_busy)
            done_d = 1'b0;
        // Completion outranks any clear landing on the same edge.
        if (seq_done)
            done_d = 1'b1;
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_OPERANDS: rdata[OPS_W-1:0] = operands_q;
            REG_CTRL:     rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
            REG_STATUS: begin
                rdata[STATUS_BUSY_BIT] = seq_busy;
                rdata[STATUS_DONE_BIT] = done_q;
            end
            REG_RESULT:   rdata[RESULT_W-1:0] = seq_result;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            operands_q <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            irq_o      <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
        end else begin
            operands_q <= operands_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            irq_o      <= done_d & irq_en_d;
            wbs_ack_o  <= in_window;
            wbs_dat_o  <= in_window ? rdata : '0;
        end
    end

    mult5_seq u_seq (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .start  (seq_start),
        .a      (operands_q[OP_A_LSB +: OPERAND_W]),
        .b      (operands_q[OP_B_LSB +: OPERAND_W]),
        .busy   (seq_busy),
        .done   (seq_done),
        .result (seq_result)
    );

endmodule

// File: tb/tb_wb_mult5_slave.sv
// Self-checking bench for wb_mult5_slave: bus tasks, a product scoreboard and a bit-level operand model.
// Expected products are queued at START and popped when RESULT is read after completion.
module tb_wb_mult5_slave;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] OFF_OPS = 32'h00;
    localparam logic [31:0] OFF_CTRL = 32'h04;
    localparam logic [31:0] OFF_STAT = 32'h08;
    localparam logic [31:0] OFF_RES = 32'h0C;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        irq_o;

    int          n_checks = 0;
    int          n_bad = 0;
    int          n_done = 0;
    int          exp_q[$];
    logic [9:0]  ops_model;

    wb_mult5_slave #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .irq_o     (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(negedge wb_clk_i) if (dut.u_seq.done) n_done++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rdat);
        bit got;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
        got  = 1'b0;
        rdat = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin
                got  = 1'b1;
                rdat = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        check("ack_seen", got, 1'b1);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(1'b0, BASE + off, 4'hF, 32'h0, d);
        check(tag, d, exp);
    endtask

    task automatic write_ops(input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        if (sel[0]) ops_model[7:0] = dat[7:0];
        if (sel[1]) ops_model[9:8] = dat[9:8];
        wb_xfer(1'b1, BASE + OFF_OPS, sel, dat, d);
    endtask

    task automatic start_op(input logic [31:0] ctrl);
        logic [31:0] d;
        exp_q.push_back(int'(ops_model[4:0]) * int'(ops_model[9:5]));
        wb_xfer(1'b1, BASE + OFF_CTRL, 4'hF, ctrl, d);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (dut.u_seq.busy) n++;
            @(posedge wb_clk_i); #1;
        end
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] st, r;
        bit seen;
        seen = 1'b0;
        st = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            wb_xfer(1'b0, BASE + OFF_STAT, 4'hF, 32'h0, st);
            if (st[1]) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_status"}, st, 32'h2);
        wb_xfer(1'b0, BASE + OFF_RES, 4'hF, 32'h0, r);
        check({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) check({tag, "_result"}, r, exp_q.pop_front());
    endtask

    initial begin
        int nb, n_ack, done0;
        logic [31:0] d;

        wb_rst_i = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
        ops_model = '0;

        // In-window request held while reset is asserted must not be acked
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = BASE + OFF_STAT; wbs_sel_i = 4'hF;
        n_ack = 0;
        repeat (4) begin @(posedge wb_clk_i); #1; if (wbs_ack_o) n_ack++; end
        check("rst_no_ack", n_ack, 0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check("rst_dat_o", wbs_dat_o, 32'h0);
        check("rst_irq", irq_o, 1'b0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        rd_check("rst_ops", OFF_OPS, 32'h0);
        rd_check("rst_ctrl", OFF_CTRL, 32'h0);
        rd_check("rst_status", OFF_STAT, 32'h0);
        rd_check("rst_result", OFF_RES, 32'h0);
        check("dat_o_idle", wbs_dat_o, 32'h0);

        // 31 x 31, busy window length, maximum product
        write_ops(32'h3FF, 4'hF);
        rd_check("ops_3ff", OFF_OPS, 32'h3FF);
        start_op(32'h1);
        count_busy(nb);
        check("busy_cycles", nb, 5);
        wait_done("max");
        rd_check("ctrl_start_reads0", OFF_CTRL, 32'h0);

        // 5 x 6 with interrupt, then RW1C clear
        write_ops(32'h0C5, 4'hF);
        start_op(32'h3);
        wait_done("irq");
        check("irq_set", irq_o, 1'b1);
        rd_check("ctrl_irq_en", OFF_CTRL, 32'h2);
        wb_xfer(1'b1, BASE + OFF_STAT, 4'hF, 32'h2, d);
        check("irq_cleared", irq_o, 1'b0);
        rd_check("done_cleared", OFF_STAT, 32'h0);
        rd_check("result_held", OFF_RES, 32'd30);

        // 7 x 3 with OPERANDS rewrite and a second START while running
        write_ops(32'h067, 4'hF);
        done0 = n_done;
        start_op(32'h3);
        write_ops(32'h021, 4'hF);
        wb_xfer(1'b1, BASE + OFF_CTRL, 4'hF, 32'h3, d);
        wait_done("inflight");
        repeat (15) @(posedge wb_clk_i);
        #1;
        check("one_completion", n_done - done0, 1);
        rd_check("no_restart", OFF_STAT, 32'h2);
        rd_check("ops_readback", OFF_OPS, {22'h0, ops_model});

        // Byte-lane write: only lane 1 (bits [9:8]) changes
        write_ops(32'h0000_0300, 4'b0010);
        rd_check("sel_lane1", OFF_OPS, {22'h0, ops_model});

        // Out-of-window request held for 10 cycles
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE + 32'h100; wbs_sel_i = 4'hF;
        n_ack = 0;
        repeat (10) begin @(posedge wb_clk_i); #1; if (wbs_ack_o) n_ack++; end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check("oow_no_ack", n_ack, 0);
        rd_check("unmapped_rd", 32'h40, 32'h0);
        wb_xfer(1'b1, BASE + 32'h40, 4'hF, 32'hFFFF_FFFF, d);
        rd_check("unmapped_wr_ignored", OFF_OPS, {22'h0, ops_model});

        // Reset during the third RUN cycle
        start_op(32'h1);
        @(posedge wb_clk_i);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        exp_q.delete();
        ops_model = '0;
        check("midrun_rst_busy", dut.u_seq.busy, 1'b0);
        check("midrun_rst_ack", wbs_ack_o, 1'b0);
        check("midrun_rst_irq", irq_o, 1'b0);
        rd_check("midrun_rst_status", OFF_STAT, 32'h0);
        rd_check("midrun_rst_result", OFF_RES, 32'h0);
        rd_check("midrun_rst_ops", OFF_OPS, 32'h0);
        write_ops(32'h22D, 4'hF);
        start_op(32'h1);
        wait_done("post_rst");

        // A few random operand pairs
        for (int k = 0; k < 4; k++) begin
            logic [4:0] ra, rb;
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            write_ops({22'h0, rb, ra}, 4'hF);
            start_op(32'h1);
            wait_done("rand");
        end
        write_ops(32'h0, 4'hF);
        start_op(32'h1);
        wait_done("zero");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
